// File: rtl/ring_chk_pkg.sv
// ring_chk_pkg: shared states, error-counter constants and ring rotate helper for ring_sequence_checker
package ring_chk_pkg;
  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;
  localparam int ERRCNT_W = 8;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'd255;
  // Rotate the low w bits of v left by one; bits above w are cleared.
  function automatic logic [31:0] rol1(input logic [31:0] v, input int w);
    rol1 = ((v << 1) | (v >> (w - 1))) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/onehot_to_bin.sv
// onehot_to_bin: combinational one-hot to binary encoder with a legal (exactly-one-bit) flag
module onehot_to_bin #(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic [IW-1:0]    bin,
  output logic             legal
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) bin = code[i] ? (bin | IW'(i)) : bin;
  end
  assign legal = $onehot(code);
endmodule

// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker: lock/track checker for a one-hot ring code stream (WIDTH <= 32).
// Define RING_CHK_ERRCNT_EN to build the saturating in-lock error counter; otherwise err_count is 0.
module ring_sequence_checker
  import ring_chk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LOCK_N = 2,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    din,
  input  logic                din_valid,
  output logic [IW-1:0]       idx,
  output logic                idx_valid,
  output logic                locked,
  output logic                err_pulse,
  output logic [ERRCNT_W-1:0] err_count
);
  state_t state, state_n;
  logic [WIDTH-1:0] prev, exp_code;
  logic [3:0] step_cnt, step_n;
  logic [IW-1:0] bin;
  logic legal, correct, err_n;

  onehot_to_bin #(.WIDTH(WIDTH)) u_enc (.code(din), .bin(bin), .legal(legal));

  assign exp_code = WIDTH'(rol1(32'(prev), WIDTH));
  assign correct = legal && din == exp_code;

  always_comb begin
    state_n = state;
    step_n = step_cnt;
    err_n = 1'b0;
    if (din_valid)
      case (state)
        HUNT: begin
          state_n = legal ? ACQUIRE : HUNT;
          step_n = '0;
        end
        ACQUIRE: begin
          step_n = correct ? step_cnt + 4'd1 : '0;
          state_n = !legal ? HUNT : (correct && step_cnt + 4'd1 == 4'(LOCK_N)) ? LOCKED : ACQUIRE;
        end
        LOCKED: begin
          err_n = !correct;
          state_n = correct ? LOCKED : legal ? ACQUIRE : HUNT;
          step_n = '0;
        end
        default: state_n = HUNT;
      endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      step_cnt <= '0;
      prev <= '0;
      idx <= '0;
      idx_valid <= 1'b0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_n;
      step_cnt <= step_n;
      idx_valid <= din_valid && legal;
      locked <= state_n == LOCKED;
      err_pulse <= err_n;
      if (din_valid && legal) begin
        prev <= din;
        idx <= bin;
      end
    end
  end

`ifdef RING_CHK_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (err_n && err_count != ERRCNT_MAX) err_count <= err_count + 1'b1;
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_ring_sequence_checker.sv
// tb_ring_sequence_checker: scoreboard bench against an index-arithmetic reference model
module tb_ring_sequence_checker;
  localparam int W = 4;
  localparam int LN = 2;
  localparam int IW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic [IW-1:0] idx;
  logic idx_valid, locked, err_pulse;
  logic [7:0] err_count;

  ring_sequence_checker #(.WIDTH(W), .LOCK_N(LN)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .idx(idx),
    .idx_valid(idx_valid), .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int iv;
    int lk;
    int ep;
    int ec;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  int dut_pulses = 0, model_pulses = 0;

  // mode: 0 searching, 1 counting correct rotations, 2 locked
  int m_mode = 0, m_prev = -1, m_run = 0, m_idx = 0, m_cnt = 0, m_iv = 0, m_ep = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("idx", int'(idx), e.idx);
      chk("idx_valid", int'(idx_valid), e.iv);
      chk("locked", int'(locked), e.lk);
      chk("err_pulse", int'(err_pulse), e.ep);
      chk("err_count", int'(err_count), e.ec);
      if (err_pulse) dut_pulses++;
    end
  end

  task automatic model(input logic r, input logic v, input logic [W-1:0] d);
    exp_t e;
    int ni;
    bit lg, ok;
    ni = -1;
    for (int i = 0; i < W; i++) if (d[i]) ni = i;
    lg = $countones(d) == 1;
    ok = lg && m_prev >= 0 && ni == (m_prev + 1) % W;
    m_iv = 0;
    m_ep = 0;
    if (r) begin
      m_mode = 0; m_prev = -1; m_run = 0; m_idx = 0; m_cnt = 0;
    end else if (v) begin
      m_iv = int'(lg);
      if (m_mode == 0) begin
        if (lg) begin m_mode = 1; m_run = 0; end
      end else if (m_mode == 1) begin
        if (!lg) m_mode = 0;
        else if (ok) begin
          m_run++;
          if (m_run == LN) m_mode = 2;
        end else m_run = 0;
      end else if (!ok) begin
        m_ep = 1;
        model_pulses++;
`ifdef RING_CHK_ERRCNT_EN
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
`endif
        m_mode = lg ? 1 : 0;
        m_run = 0;
      end
      if (lg) begin m_prev = ni; m_idx = ni; end
    end
    e.idx = m_idx; e.iv = m_iv; e.lk = int'(m_mode == 2); e.ep = m_ep; e.ec = m_cnt;
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
    @(negedge clk);
    rst = r;
    din_valid = v;
    din = d;
    model(r, v, d);
  endtask

  function automatic logic [W-1:0] code_of(input int k);
    logic [W-1:0] one;
    one = 1;
    return one << k;
  endfunction

  function automatic logic [W-1:0] next_code();
    return code_of(m_prev < 0 ? 0 : (m_prev + 1) % W);
  endfunction

  task automatic relock();
    for (int i = 0; i <= LN; i++) drive(1'b0, 1'b1, next_code());
  endtask

  initial begin
    int sel;
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 4'b1000);
    drive(1'b0, 1'b1, 4'b1000);
    drive(1'b0, 1'b1, 4'b0001);
    drive(1'b0, 1'b1, 4'b0010);
    drive(1'b0, 1'b1, 4'b0110);
    drive(1'b0, 1'b1, 4'b0100);
    relock();
    drive(1'b0, 1'b1, next_code());
    drive(1'b0, 1'b1, code_of(m_prev));
    relock();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b1111);
    drive(1'b0, 1'b1, next_code());
    for (int i = 0; i < 260; i++) begin
      relock();
      drive(1'b0, 1'b1, 4'b0110);
    end
    relock();
    drive(1'b1, 1'b1, next_code());
    drive(1'b0, 1'b1, 4'b0100);
    drive(1'b0, 1'b1, 4'b1000);
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 9);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
            sel < 7 ? next_code() : sel == 7 ? code_of(m_prev < 0 ? 0 : m_prev) :
            sel == 8 ? code_of($urandom_range(0, W - 1)) : W'($urandom));
    end
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("err_pulse_total", dut_pulses, model_pulses);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
